// File: rtl/sbio_out_arbiter.sv
// rtl/sbio_out_arbiter.sv - round-robin arbiter sharing one registered SB_IO output bank
// Bursts are bounded by MAX_BURST beats; each release is followed by TURNAROUND cycles with OE low.
module sbio_out_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 8,
  parameter int MAX_BURST  = 16,
  parameter int TURNAROUND = 1,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [OW-1:0]            owner,
  output logic                     busy,
  output logic [WIDTH-1:0]         pin_dout,
  output logic                     pin_oe
);

  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int TW = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        rr_q, rr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        turn_q, turn_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 oe_q, oe_d;

  logic                 pick_found;
  logic [OW-1:0]        pick_idx;
  int                   cand;
  logic                 release_own;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_q) + i) % NUM_REQ;
      if (!pick_found && req[cand[OW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[OW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    turn_d      = turn_q;
    dout_d      = dout_q;
    oe_d        = 1'b0;
    release_own = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_OWN;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      S_OWN: begin
        if (req[owner_q]) begin
          dout_d = req_data[int'(owner_q)*WIDTH +: WIDTH];
          oe_d   = 1'b1;
          // Unbounded bursts need no count, so it stays frozen and cannot wrap.
          if (MAX_BURST != 0) begin
            cnt_d = cnt_q + CW'(1);
            if (int'(cnt_q) + 1 >= MAX_BURST) release_own = 1'b1;
          end
        end else begin
          release_own = 1'b1;
        end
        if (release_own) begin
          gnt_d = '0;
          rr_d  = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + OW'(1);
          if (TURNAROUND > 0) begin
            state_d = S_TURN;
            turn_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_TURN: begin
        turn_d = turn_q + TW'(1);
        if (int'(turn_q) >= TURNAROUND - 1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      turn_q  <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
    end
  end

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign busy     = (state_q != S_IDLE);
  assign pin_dout = dout_q;
  assign pin_oe   = oe_q;

endmodule

// File: tb/tb_sbio_out_arbiter.sv
// tb/tb_sbio_out_arbiter.sv - self-checking bench for sbio_out_arbiter
// Vector table, corner-case sequences, and random traffic against a reference model.
module tb_sbio_out_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int TA = 1;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     gnt;
  logic [1:0]       owner;
  logic             busy;
  logic [W-1:0]     pin_dout;
  logic             pin_oe;

  logic [N-1:0]     req_u = '0;
  logic [N*W-1:0]   data_u = '0;
  logic [N-1:0]     gnt_u;
  logic [1:0]       owner_u;
  logic             busy_u;
  logic [W-1:0]     pin_dout_u;
  logic             pin_oe_u;

  sbio_out_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB), .TURNAROUND(TA)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data),
    .gnt(gnt), .owner(owner), .busy(busy), .pin_dout(pin_dout), .pin_oe(pin_oe)
  );

  sbio_out_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(0), .TURNAROUND(1)) dut_u (
    .clock(clock), .reset_n(reset_n), .req(req_u), .req_data(data_u),
    .gnt(gnt_u), .owner(owner_u), .busy(busy_u), .pin_dout(pin_dout_u), .pin_oe(pin_oe_u)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        oe;
    logic [7:0]  dout;
    logic [1:0]  owner;
    logic        busy;
  } vec_t;

  vec_t vecs[12];

  // Reference model: owner index (-1 = none), remaining gap cycles, pointer, beat count.
  int         m_own, m_gap, m_rr, m_cnt, e_owner;
  logic [3:0] e_gnt;
  logic       e_oe, e_busy;
  logic [7:0] e_dout;

  task automatic model_reset();
    m_own = -1; m_gap = 0; m_rr = 0; m_cnt = 0; e_owner = 0;
    e_gnt = '0; e_oe = 1'b0; e_busy = 1'b0; e_dout = '0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [31:0] d);
    bit rel;
    rel  = 0;
    e_oe = 1'b0;
    if (m_own >= 0) begin
      if (r[m_own]) begin
        e_dout = d[m_own*8 +: 8];
        e_oe   = 1'b1;
        m_cnt++;
        rel = (MB != 0) && (m_cnt == MB);
      end else begin
        rel = 1;
      end
      if (rel) begin
        m_rr  = (m_own + 1) % N;
        m_own = -1;
        m_gap = TA;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (r != 0) begin
      for (int i = 0; i < N; i++)
        if (m_own < 0 && r[(m_rr + i) % N]) m_own = (m_rr + i) % N;
      m_cnt   = 0;
      e_owner = m_own;
    end
    e_gnt  = (m_own >= 0) ? 4'(1 << m_own) : 4'b0;
    e_busy = (m_own >= 0) || (m_gap > 0);
  endtask

  task automatic do_reset();
    req = '0; req_data = '0; req_u = '0; data_u = '0;
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  int         order[$];
  int         lens[$];
  int         gaps[$];
  int         glen, low, bad_cnt, hcnt, ocnt;
  bit         seen;
  logic [3:0] pg;
  int         exp2[5] = '{0, 1, 2, 3, 0};
  int         exp3[6] = '{0, 2, 0, 2, 0, 2};

  task automatic track_clear();
    order.delete(); lens.delete(); gaps.delete();
    glen = 0; low = 0; bad_cnt = 0; seen = 0; pg = '0;
  endtask

  task automatic track_cycle();
    if (gnt != 0 && pg == 0) order.push_back(int'(owner));
    if (gnt != 0) glen++;
    else if (pg != 0) begin
      lens.push_back(glen);
      glen = 0;
    end
    if (pin_oe) begin
      if (seen && low > 0) gaps.push_back(low);
      low  = 0;
      seen = 1;
    end else begin
      low++;
    end
    pg = gnt;
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 32'h00000000, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1};
    vecs[1]  = '{4'b0001, 32'h99887711, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1};
    vecs[2]  = '{4'b0001, 32'h12345622, 4'b0001, 1'b1, 8'h22, 2'd0, 1'b1};
    vecs[3]  = '{4'b0001, 32'hABCDEF33, 4'b0001, 1'b1, 8'h33, 2'd0, 1'b1};
    vecs[4]  = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 8'h33, 2'd0, 1'b1};
    vecs[5]  = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 8'h33, 2'd0, 1'b0};
    vecs[6]  = '{4'b0110, 32'h00000000, 4'b0010, 1'b0, 8'h33, 2'd1, 1'b1};
    vecs[7]  = '{4'b0100, 32'hFFFFFFFF, 4'b0000, 1'b0, 8'h33, 2'd1, 1'b1};
    vecs[8]  = '{4'b0100, 32'h00000000, 4'b0000, 1'b0, 8'h33, 2'd1, 1'b0};
    vecs[9]  = '{4'b0100, 32'h00000000, 4'b0100, 1'b0, 8'h33, 2'd2, 1'b1};
    vecs[10] = '{4'b0100, 32'h775A3344, 4'b0100, 1'b1, 8'h5A, 2'd2, 1'b1};
    vecs[11] = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 8'h5A, 2'd2, 1'b1};

    do_reset();
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_owner", 32'(owner), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_dout", 32'(pin_dout), 0);
    chk("reset_oe", 32'(pin_oe), 0);

    for (int v = 0; v < 12; v++) begin
      req = vecs[v].req;
      req_data = vecs[v].data;
      @(negedge clock);
      chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(vecs[v].gnt));
      chk($sformatf("vec%0d_oe", v), 32'(pin_oe), 32'(vecs[v].oe));
      chk($sformatf("vec%0d_dout", v), 32'(pin_dout), 32'(vecs[v].dout));
      chk($sformatf("vec%0d_owner", v), 32'(owner), 32'(vecs[v].owner));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
    end

    // All four requesting: 4-beat bursts in rotation with a 2-cycle OE gap.
    do_reset();
    track_clear();
    req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      req_data = $urandom;
      @(negedge clock);
      if (!$onehot0(gnt)) bad_cnt++;
      track_cycle();
    end
    chk("all_req_onehot_bad", 32'(bad_cnt), 0);
    for (int i = 0; i < 5; i++)
      chk($sformatf("all_req_order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'hFFFFFFFF, 32'(exp2[i]));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("all_req_len%0d", i), (i < lens.size()) ? 32'(lens[i]) : 32'hFFFFFFFF, 4);
      chk($sformatf("all_req_gap%0d", i), (i < gaps.size()) ? 32'(gaps[i]) : 32'hFFFFFFFF, 2);
    end

    // Requesters 0 and 2 held: they alternate, 1 and 3 never granted.
    do_reset();
    track_clear();
    req = 4'b0101;
    for (int c = 0; c < 45; c++) begin
      req_data = $urandom;
      @(negedge clock);
      if (gnt[1] || gnt[3]) bad_cnt++;
      track_cycle();
    end
    chk("alt_idle_grants", 32'(bad_cnt), 0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("alt_order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'hFFFFFFFF, 32'(exp3[i]));

    // Asynchronous reset in the middle of owner 2's burst.
    do_reset();
    req = 4'b0100;
    req_data = 32'h00AB0000;
    repeat (3) @(negedge clock);
    chk("mid_pre_gnt", 32'(gnt), 32'h4);
    chk("mid_pre_oe", 32'(pin_oe), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_owner", 32'(owner), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_dout", 32'(pin_dout), 0);
    chk("mid_rst_oe", 32'(pin_oe), 0);
    req = 4'b1111;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("mid_after_gnt", 32'(gnt), 32'h1);
    chk("mid_after_owner", 32'(owner), 0);

    // Unbounded burst: requester 3 held for 300 cycles.
    do_reset();
    req_u = 4'b1000;
    data_u = 32'h5C000000;
    hcnt = 0; ocnt = 0;
    repeat (300) begin
      @(negedge clock);
      if (gnt_u[3]) hcnt++;
      if (pin_oe_u) ocnt++;
    end
    req_u = '0;
    @(negedge clock);
    if (pin_oe_u) ocnt++;
    chk("unb_gnt_cycles", 32'(hcnt), 300);
    chk("unb_beats", 32'(ocnt), 299);
    chk("unb_released", 32'(gnt_u), 0);
    chk("unb_dout", 32'(pin_dout_u), 32'h5C);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000 && errors < 20; c++) begin
      @(negedge clock);
      chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
      chk("rnd_oe", 32'(pin_oe), 32'(e_oe));
      chk("rnd_dout", 32'(pin_dout), 32'(e_dout));
      chk("rnd_owner", 32'(owner), 32'(e_owner));
      chk("rnd_busy", 32'(busy), 32'(e_busy));
      if ($urandom_range(3) == 0) req = 4'($urandom);
      req_data = $urandom;
      model_step(req, req_data);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
